// File: rtl/lbp_stream.sv
// lbp_stream: streaming RGB -> gray -> 3x3 LBP engine, one pixel per clock.
// Fetches an IMG_W x IMG_H frame in raster order from host RGB memory and
// writes every gray pixel plus the LBP code of each interior pixel.
// LBP uses two line buffers and a 3x3 window; no full-frame gray memory.
// Optional build macro GRAY_WEIGHTED_EN: luma-weighted gray conversion
// with one extra pipeline stage (default build: plain /3 average).
module lbp_stream #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 14,
    parameter int PIX_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 RGB_ready,
    output logic [ADDR_W-1:0]    RGB_addr,
    output logic                 RGB_req,
    input  logic [3*PIX_W-1:0]   RGB_data,
    output logic [ADDR_W-1:0]    gray_addr,
    output logic                 gray_valid,
    output logic [PIX_W-1:0]     gray_data,
    output logic [ADDR_W-1:0]    lbp_addr,
    output logic                 lbp_valid,
    output logic [7:0]           lbp_data,
    output logic                 finish
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [ADDR_W-1:0] LBP_OFS   = ADDR_W'(IMG_W + 1);
`ifdef GRAY_WEIGHTED_EN
    localparam int DRAIN_LEN = 3;
    localparam int WW        = 16 + PIX_W;
`else
    localparam int DRAIN_LEN = 2;
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t              state;
    logic [1:0]          drain_cnt;
    logic [ADDR_W-1:0]   req_k;

    // read-return pipeline
    logic                rd_v;
    logic [ADDR_W-1:0]   rd_addr;
    logic [PIX_W-1:0]    conv_gray;

    // pixel entering the gray/LBP stage
    logic                px_v;
    logic [ADDR_W-1:0]   px_addr;
    logic [PIX_W-1:0]    px_gray;

    // raster position of the pixel entering the gray/LBP stage
    logic [CW-1:0]       col;
    logic [RW-1:0]       row;

    // line buffers: lb0 holds the previous row, lb1 the one before it
    logic [PIX_W-1:0]    lb0 [IMG_W];
    logic [PIX_W-1:0]    lb1 [IMG_W];

    // window columns c-2 (x0) and c-1 (x1); t/m/b = rows r-2, r-1, r
    logic [PIX_W-1:0]    wt0, wm0, wb0, wt1, wm1, wb1;
    logic [PIX_W-1:0]    top_n, mid_n;
    logic [7:0]          code;
    logic                fire;

    // Requests are gated combinationally by RGB_ready so a stall takes effect the same cycle
    assign RGB_req  = (state == RUN) && RGB_ready;
    assign RGB_addr = req_k;

    // Frame sequencer: request counter, drain timing and finish pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            req_k     <= '0;
            drain_cnt <= '0;
            finish    <= 1'b0;
        end else begin
            finish <= 1'b0;
            case (state)
                IDLE: begin
                    if (RGB_ready) begin
                        state <= RUN;
                        req_k <= '0;
                    end
                end
                RUN: begin
                    if (RGB_ready) begin
                        if (req_k == LAST_ADDR) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            req_k <= req_k + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 2'(DRAIN_LEN - 1)) begin
                        state  <= DONE;
                        finish <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Track which cycle carries returned RGB data and its address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_v    <= 1'b0;
            rd_addr <= '0;
        end else begin
            rd_v <= RGB_req;
            if (RGB_req) rd_addr <= RGB_addr;
        end
    end

`ifdef GRAY_WEIGHTED_EN
    logic [WW-1:0]     wsum;
    logic              s_v;
    logic [ADDR_W-1:0] s_addr;
    logic [PIX_W-1:0]  s_gray;

    // Weighted luma; the 256 total weight makes >>8 a normalised average
    always_comb begin
        wsum = WW'(77)  * WW'(RGB_data[3*PIX_W-1:2*PIX_W])
             + WW'(150) * WW'(RGB_data[2*PIX_W-1:PIX_W])
             + WW'(29)  * WW'(RGB_data[PIX_W-1:0]);
        conv_gray = PIX_W'(wsum >> 8);
    end

    // Extra stage isolating the multiply-add from the window logic
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_v    <= 1'b0;
            s_addr <= '0;
            s_gray <= '0;
        end else begin
            s_v <= rd_v;
            if (rd_v) begin
                s_addr <= rd_addr;
                s_gray <= conv_gray;
            end
        end
    end

    // Stage input taken from the extra register
    always_comb begin
        px_v    = s_v;
        px_addr = s_addr;
        px_gray = s_gray;
    end
`else
    logic [PIX_W+1:0] sum3;

    // Plain average; PIX_W+2 bits hold the sum of three channels
    always_comb begin
        sum3 = (PIX_W+2)'(RGB_data[3*PIX_W-1:2*PIX_W])
             + (PIX_W+2)'(RGB_data[2*PIX_W-1:PIX_W])
             + (PIX_W+2)'(RGB_data[PIX_W-1:0]);
        conv_gray = PIX_W'(sum3 / (PIX_W+2)'(3));
    end

    // Stage input taken straight from the returning data
    always_comb begin
        px_v    = rd_v;
        px_addr = rd_addr;
        px_gray = conv_gray;
    end
`endif

    // Raster position of the incoming gray pixel, restarted for every frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col <= '0;
            row <= '0;
        end else if (state == IDLE) begin
            col <= '0;
            row <= '0;
        end else if (px_v) begin
            if (col == CW'(IMG_W - 1)) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Line buffers and window shift; contents are don't-care until rows/cols 0..1 of this frame are in
    always_ff @(posedge clk) begin
        if (px_v) begin
            lb1[col] <= lb0[col];
            lb0[col] <= px_gray;
            wt0      <= wt1;
            wm0      <= wm1;
            wb0      <= wb1;
            wt1      <= top_n;
            wm1      <= mid_n;
            wb1      <= px_gray;
        end
    end

    // LBP code of centre (r-1,c-1), compared against the window plus the incoming column
    always_comb begin
        top_n   = lb1[col];
        mid_n   = lb0[col];
        code[0] = wt0     >= wm1;
        code[1] = wt1     >= wm1;
        code[2] = top_n   >= wm1;
        code[3] = wm0     >= wm1;
        code[4] = mid_n   >= wm1;
        code[5] = wb0     >= wm1;
        code[6] = wb1     >= wm1;
        code[7] = px_gray >= wm1;
        // col>=2 keeps the window inside one row, so no wrap across rows
        fire    = px_v && (row >= RW'(2)) && (col >= CW'(2));
    end

    // Registered gray and LBP write ports; data holds between strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gray_valid <= 1'b0;
            gray_addr  <= '0;
            gray_data  <= '0;
            lbp_valid  <= 1'b0;
            lbp_addr   <= '0;
            lbp_data   <= '0;
        end else begin
            gray_valid <= px_v;
            if (px_v) begin
                gray_addr <= px_addr;
                gray_data <= px_gray;
            end
            lbp_valid <= fire;
            if (fire) begin
                lbp_addr <= px_addr - LBP_OFS;
                lbp_data <= code;
            end
        end
    end

endmodule

// File: tb/tb_lbp_stream.sv
// tb_lbp_stream: directed bench for lbp_stream on a 4x4 frame.
// A host model answers RGB requests one cycle later; a monitor captures
// gray/LBP writes, request order and timing; the main sequence checks them.
module tb_lbp_stream;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int AW   = 4;
    localparam int PW   = 8;
    localparam int NPIX = W * H;
`ifdef GRAY_WEIGHTED_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          RGB_ready = 1'b0;
    logic [AW-1:0] RGB_addr;
    logic          RGB_req;
    logic [23:0]   RGB_data = 24'h5A5A5A;
    logic [AW-1:0] gray_addr;
    logic          gray_valid;
    logic [PW-1:0] gray_data;
    logic [AW-1:0] lbp_addr;
    logic          lbp_valid;
    logic [7:0]    lbp_data;
    logic          finish;

    always #5 clk = ~clk;

    lbp_stream #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PIX_W(PW)) dut (
        .clk(clk), .reset_n(reset_n), .RGB_ready(RGB_ready),
        .RGB_addr(RGB_addr), .RGB_req(RGB_req), .RGB_data(RGB_data),
        .gray_addr(gray_addr), .gray_valid(gray_valid), .gray_data(gray_data),
        .lbp_addr(lbp_addr), .lbp_valid(lbp_valid), .lbp_data(lbp_data),
        .finish(finish)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int pat = 1;

    function automatic logic [23:0] pix(input int a);
        int c;
        c = a % W;
        case (pat)
            1: return 24'h0A0B0C;
            2: return {8'(c), 8'(c), 8'(c)};
            4: return 24'hFF0000;
            default: return {8'(a * 37 + 5), 8'(a * 11 + 200), 8'(a * 53)};
        endcase
    endfunction

    function automatic int exp_gray(input int a);
        logic [23:0] v;
        int r, g, b;
        v = pix(a);
        r = int'(v[23:16]);
        g = int'(v[15:8]);
        b = int'(v[7:0]);
`ifdef GRAY_WEIGHTED_EN
        return (77 * r + 150 * g + 29 * b) >> 8;
`else
        return (r + g + b) / 3;
`endif
    endfunction

    function automatic int exp_lbp(input int a);
        int dr[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
        int dc[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
        int r, c, ctr, code;
        r = a / W;
        c = a % W;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
        ctr = exp_gray(a);
        code = 0;
        for (int k = 0; k < 8; k++)
            if (exp_gray((r + dr[k]) * W + c + dc[k]) >= ctr) code = code | (1 << k);
        return code;
    endfunction

    task automatic check(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, expv, expv);
        end
    endtask

    // host memory model: data for a request appears the following cycle
    logic          dreq;
    logic [AW-1:0] daddr;
    always begin
        @(negedge clk);
        dreq  = RGB_req;
        daddr = RGB_addr;
        @(posedge clk);
        #1;
        RGB_data = dreq ? pix(int'(daddr)) : 24'h5A5A5A;
    end

    // monitor state (written only by the monitor)
    int clr_seq = 0;
    int clr_seen = 0;
    int cyc = 0;
    int n_req, exp_ra, req_bad, first_req, last_req;
    int n_g, last_g, first_g, ord_bad;
    int n_l, last_l, first_l, last_l_cyc, border_bad;
    int n_fin, fin_cyc;
    int fin_total = 0;
    logic [7:0] gmem [NPIX];
    logic [7:0] lmem [NPIX];

    always @(negedge clk) begin
        int r, c;
        cyc++;
        if (clr_seen != clr_seq) begin
            clr_seen = clr_seq;
            n_req = 0; exp_ra = 0; req_bad = 0; first_req = 0; last_req = 0;
            n_g = 0; last_g = 0; first_g = 0; ord_bad = 0;
            n_l = 0; last_l = 0; first_l = 0; last_l_cyc = 0; border_bad = 0;
            n_fin = 0; fin_cyc = 0;
            for (int i = 0; i < NPIX; i++) begin
                gmem[i] = '0;
                lmem[i] = '0;
            end
        end
        if (RGB_req) begin
            if (int'(RGB_addr) != exp_ra || !RGB_ready) req_bad++;
            exp_ra++;
            if (n_req == 0) first_req = cyc;
            last_req = cyc;
            n_req++;
        end
        if (gray_valid) begin
            if (n_g > 0 && int'(gray_addr) <= last_g) ord_bad++;
            if (n_g == 0) first_g = cyc;
            gmem[gray_addr] = gray_data;
            last_g = int'(gray_addr);
            n_g++;
        end
        if (lbp_valid) begin
            r = int'(lbp_addr) / W;
            c = int'(lbp_addr) % W;
            if (r == 0 || r == H - 1 || c == 0 || c == W - 1) border_bad++;
            if (n_l > 0 && int'(lbp_addr) <= last_l) ord_bad++;
            if (n_l == 0) first_l = cyc;
            lmem[lbp_addr] = lbp_data;
            last_l = int'(lbp_addr);
            last_l_cyc = cyc;
            n_l++;
        end
        if (finish) begin
            n_fin++;
            fin_total++;
            fin_cyc = cyc;
            if (gray_valid || lbp_valid) ord_bad++;
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req"},   int'(RGB_req),    0);
        check({tag, "_raddr"}, int'(RGB_addr),   0);
        check({tag, "_gv"},    int'(gray_valid), 0);
        check({tag, "_gaddr"}, int'(gray_addr),  0);
        check({tag, "_gdata"}, int'(gray_data),  0);
        check({tag, "_lv"},    int'(lbp_valid),  0);
        check({tag, "_laddr"}, int'(lbp_addr),   0);
        check({tag, "_ldata"}, int'(lbp_data),   0);
        check({tag, "_fin"},   int'(finish),     0);
    endtask

    task automatic check_frame(input string tag, input int st_len);
        check({tag, "_nreq"},   n_req, NPIX);
        check({tag, "_reqbad"}, req_bad, 0);
        check({tag, "_ngray"},  n_g, NPIX);
        check({tag, "_nlbp"},   n_l, (W - 2) * (H - 2));
        check({tag, "_order"},  ord_bad, 0);
        check({tag, "_border"}, border_bad, 0);
        check({tag, "_nfin"},   n_fin, 1);
        check({tag, "_reqspan"}, last_req - first_req, NPIX - 1 + st_len);
        check({tag, "_graylat"}, first_g - first_req, LAT);
        check({tag, "_finlat"},  fin_cyc - last_req, LAT + 1);
        check({tag, "_lbp2fin"}, fin_cyc - last_l_cyc, 1);
        if (st_len == 0) check({tag, "_lbplat"}, first_l - first_g, 2 * W + 2);
        for (int a = 0; a < NPIX; a++) begin
            check($sformatf("%s_gray%0d", tag, a), int'(gmem[a]), exp_gray(a));
            check($sformatf("%s_lbp%0d", tag, a), int'(lmem[a]), exp_lbp(a));
        end
    endtask

    task automatic run_frame(input string tag, input int p, input int st_at,
                             input int st_len, input bit keep);
        int  cycles;
        bit  stalled;
        pat = p;
        clr_seq++;
        RGB_ready = 1'b1;
        stalled = 1'b0;
        cycles = 0;
        @(negedge clk);
        #1;
        while (n_fin == 0 && cycles < 400) begin
            @(posedge clk);
            #1;
            cycles++;
            if (!stalled && st_len > 0 && n_req == st_at) begin
                RGB_ready = 1'b0;
                repeat (st_len) @(posedge clk);
                #1;
                RGB_ready = 1'b1;
                stalled = 1'b1;
            end
        end
        if (n_fin == 0) check({tag, "_timeout"}, 0, 1);
        if (!keep) RGB_ready = 1'b0;
        check_frame(tag, st_len);
    endtask

    initial begin
        int cycles;
        int fin0;

        // reset state, and RGB_ready must not start a frame while in reset
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("rst");
        RGB_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready_req", int'(RGB_req), 0);
        RGB_ready = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_req", int'(RGB_req), 0);

        // 1: uniform colour
        run_frame("t1", 1, 0, 0, 1'b0);
`ifndef GRAY_WEIGHTED_EN
        check("t1_gray_const", int'(gmem[7]), 8'h0B);
`endif
        check("t1_lbp_const", int'(lmem[5]), 8'hFF);

        // 2: gray equals column index
        run_frame("t2", 2, 0, 0, 1'b0);
        check("t2_lbp5_const", int'(lmem[5]), 8'hD6);
        check("t2_lbp10_const", int'(lmem[10]), 8'hD6);

        // 3: RGB_ready dropped for 5 cycles after the 7th request
        run_frame("t3", 3, 7, 5, 1'b0);

        // 4: reset asserted once address 9 has been requested
        pat = 3;
        clr_seq++;
        RGB_ready = 1'b1;
        cycles = 0;
        @(negedge clk);
        #1;
        while (n_req < 10 && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("t4_reached_addr9", n_req, 10);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("t4_rst_a");
        @(posedge clk);
        #1;
        check_outputs_zero("t4_rst_b");
        RGB_ready = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("t4_post_rst_req", int'(RGB_req), 0);
        run_frame("t4", 2, 0, 0, 1'b0);

        // 5: two frames back to back with RGB_ready held high
        fin0 = fin_total;
        run_frame("t5a", 3, 0, 0, 1'b1);
        run_frame("t5b", 1, 0, 0, 1'b0);
        check("t5_fin_pulses", fin_total - fin0, 2);

`ifdef GRAY_WEIGHTED_EN
        // 6: weighted gray of pure red
        run_frame("t6", 4, 0, 0, 1'b0);
        check("t6_red_gray", int'(gmem[0]), 8'h4C);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
